// File: rtl/ace_ccu_snoop_fanout.sv
// Snoop fan-out for the CCU: broadcasts one AC to the masked caches, merges their CR
// responses, forwards the CD line of the lowest data-supplying cache and drains the rest.
module ace_ccu_snoop_fanout #(
    parameter int unsigned NoSnoopers  = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned CdDataWidth = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              slv_ac_valid_i,
    output logic                              slv_ac_ready_o,
    input  logic [AddrWidth-1:0]              slv_ac_addr_i,
    input  logic [3:0]                        slv_ac_snoop_i,
    input  logic [2:0]                        slv_ac_prot_i,
    input  logic [NoSnoopers-1:0]             slv_ac_mask_i,
    output logic                              slv_cr_valid_o,
    input  logic                              slv_cr_ready_i,
    output logic [4:0]                        slv_cr_resp_o,
    output logic                              slv_cd_valid_o,
    input  logic                              slv_cd_ready_i,
    output logic [CdDataWidth-1:0]            slv_cd_data_o,
    output logic                              slv_cd_last_o,
    output logic [NoSnoopers-1:0]             mst_ac_valid_o,
    input  logic [NoSnoopers-1:0]             mst_ac_ready_i,
    output logic [AddrWidth-1:0]              mst_ac_addr_o,
    output logic [3:0]                        mst_ac_snoop_o,
    output logic [2:0]                        mst_ac_prot_o,
    input  logic [NoSnoopers-1:0]             mst_cr_valid_i,
    output logic [NoSnoopers-1:0]             mst_cr_ready_o,
    input  logic [5*NoSnoopers-1:0]           mst_cr_resp_i,
    input  logic [NoSnoopers-1:0]             mst_cd_valid_i,
    output logic [NoSnoopers-1:0]             mst_cd_ready_o,
    input  logic [CdDataWidth*NoSnoopers-1:0] mst_cd_data_i,
    input  logic [NoSnoopers-1:0]             mst_cd_last_i
);

    localparam int unsigned IdxWidth  = (NoSnoopers > 1) ? $clog2(NoSnoopers) : 1;
    localparam int unsigned RespWidth = 5;

    typedef enum logic [1:0] {IDLE, SNOOP, RESP, DATA} state_e;

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [3:0]              snoop_q, snoop_d;
    logic [2:0]              prot_q, prot_d;
    logic [NoSnoopers-1:0]   mask_q, mask_d;
    logic [NoSnoopers-1:0]   ac_valid_q, ac_valid_d;
    logic [NoSnoopers-1:0]   ac_done_q, ac_done_d;
    logic [NoSnoopers-1:0]   cr_done_q, cr_done_d;
    logic [NoSnoopers-1:0]   data_pend_q, data_pend_d;
    logic [RespWidth-1:0]    resp_q, resp_d;
    logic [IdxWidth-1:0]     src_q, src_d;
    logic [NoSnoopers-1:0]   cr_ready, cr_take;
    logic [NoSnoopers-1:0]   cd_ready, cd_last_take;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            snoop_q     <= '0;
            prot_q      <= '0;
            mask_q      <= '0;
            ac_valid_q  <= '0;
            ac_done_q   <= '0;
            cr_done_q   <= '0;
            data_pend_q <= '0;
            resp_q      <= '0;
            src_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            snoop_q     <= snoop_d;
            prot_q      <= prot_d;
            mask_q      <= mask_d;
            ac_valid_q  <= ac_valid_d;
            ac_done_q   <= ac_done_d;
            cr_done_q   <= cr_done_d;
            data_pend_q <= data_pend_d;
            resp_q      <= resp_d;
            src_q       <= src_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        snoop_d        = snoop_q;
        prot_d         = prot_q;
        mask_d         = mask_q;
        ac_valid_d     = ac_valid_q;
        ac_done_d      = ac_done_q;
        cr_done_d      = cr_done_q;
        data_pend_d    = data_pend_q;
        resp_d         = resp_q;
        src_d          = src_q;
        cr_ready       = '0;
        cr_take        = '0;
        cd_ready       = '0;
        cd_last_take   = '0;
        slv_ac_ready_o = 1'b0;
        slv_cr_valid_o = 1'b0;
        slv_cd_valid_o = 1'b0;
        slv_cd_data_o  = '0;
        slv_cd_last_o  = 1'b0;

        case (state_q)
            IDLE: begin
                slv_ac_ready_o = ~rst_i;
                if (slv_ac_valid_i) begin
                    addr_d      = slv_ac_addr_i;
                    snoop_d     = slv_ac_snoop_i;
                    prot_d      = slv_ac_prot_i;
                    mask_d      = slv_ac_mask_i;
                    ac_done_d   = '0;
                    cr_done_d   = '0;
                    data_pend_d = '0;
                    resp_d      = '0;
                    if (slv_ac_mask_i != '0) begin
                        ac_valid_d = slv_ac_mask_i;
                        state_d    = SNOOP;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            SNOOP: begin
                ac_valid_d = ac_valid_q & ~mst_ac_ready_i;
                ac_done_d  = ac_done_q | (ac_valid_q & mst_ac_ready_i);
                // A cache's CR is only taken once its own AC has completed.
                cr_ready   = ac_done_q & ~cr_done_q;
                cr_take    = cr_ready & mst_cr_valid_i;
                for (int i = 0; i < int'(NoSnoopers); i++) begin
                    if (cr_take[i]) begin
                        resp_d = resp_d | mst_cr_resp_i[RespWidth*i +: RespWidth];
                        if (mst_cr_resp_i[RespWidth*i]) data_pend_d[i] = 1'b1;
                    end
                end
                cr_done_d = cr_done_q | cr_take;
                if (cr_done_d == mask_q) state_d = RESP;
            end
            RESP: begin
                slv_cr_valid_o = 1'b1;
                for (int i = int'(NoSnoopers) - 1; i >= 0; i--) begin
                    if (data_pend_q[i]) src_d = IdxWidth'(i);
                end
                if (slv_cr_ready_i) state_d = (data_pend_q == '0) ? IDLE : DATA;
            end
            DATA: begin
                // Source beats pass straight through; every other pending stream is drained.
                for (int i = 0; i < int'(NoSnoopers); i++) begin
                    if (src_q == IdxWidth'(i)) begin
                        slv_cd_valid_o = data_pend_q[i] & mst_cd_valid_i[i];
                        slv_cd_data_o  = mst_cd_data_i[CdDataWidth*i +: CdDataWidth];
                        slv_cd_last_o  = mst_cd_last_i[i];
                        cd_ready[i]    = data_pend_q[i] & slv_cd_ready_i;
                    end else begin
                        cd_ready[i] = data_pend_q[i];
                    end
                end
                cd_last_take = cd_ready & mst_cd_valid_i & mst_cd_last_i;
                data_pend_d  = data_pend_q & ~cd_last_take;
                if (data_pend_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mst_cr_ready_o = cr_ready;
    assign mst_cd_ready_o = cd_ready;
    assign mst_ac_valid_o = ac_valid_q;
    assign mst_ac_addr_o  = addr_q;
    assign mst_ac_snoop_o = snoop_q;
    assign mst_ac_prot_o  = prot_q;
    assign slv_cr_resp_o  = resp_q;

endmodule

// File: tb/tb_ace_ccu_snoop_fanout.sv
// Self-checking bench for ace_ccu_snoop_fanout: cycle-stepped cache models plus a
// transaction-level reference (OR of responses, lowest data supplier forwarded).
module tb_ace_ccu_snoop_fanout;

    localparam int N    = 4;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            slv_ac_valid, slv_ac_ready_o;
    logic [AW-1:0]   slv_ac_addr;
    logic [3:0]      slv_ac_snoop;
    logic [2:0]      slv_ac_prot;
    logic [N-1:0]    slv_ac_mask;
    logic            slv_cr_valid_o, slv_cr_ready;
    logic [4:0]      slv_cr_resp_o;
    logic            slv_cd_valid_o, slv_cd_ready;
    logic [DW-1:0]   slv_cd_data_o;
    logic            slv_cd_last_o;
    logic [N-1:0]    mst_ac_valid_o, mst_ac_ready;
    logic [AW-1:0]   mst_ac_addr_o;
    logic [3:0]      mst_ac_snoop_o;
    logic [2:0]      mst_ac_prot_o;
    logic [N-1:0]    mst_cr_valid, mst_cr_ready_o;
    logic [5*N-1:0]  mst_cr_resp;
    logic [N-1:0]    mst_cd_valid, mst_cd_ready_o;
    logic [DW*N-1:0] mst_cd_data;
    logic [N-1:0]    mst_cd_last;

    always #5 clk = ~clk;

    ace_ccu_snoop_fanout #(.NoSnoopers(N), .AddrWidth(AW), .CdDataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_ac_valid_i(slv_ac_valid), .slv_ac_ready_o(slv_ac_ready_o),
        .slv_ac_addr_i(slv_ac_addr), .slv_ac_snoop_i(slv_ac_snoop),
        .slv_ac_prot_i(slv_ac_prot), .slv_ac_mask_i(slv_ac_mask),
        .slv_cr_valid_o(slv_cr_valid_o), .slv_cr_ready_i(slv_cr_ready),
        .slv_cr_resp_o(slv_cr_resp_o),
        .slv_cd_valid_o(slv_cd_valid_o), .slv_cd_ready_i(slv_cd_ready),
        .slv_cd_data_o(slv_cd_data_o), .slv_cd_last_o(slv_cd_last_o),
        .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready),
        .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
        .mst_ac_prot_o(mst_ac_prot_o),
        .mst_cr_valid_i(mst_cr_valid), .mst_cr_ready_o(mst_cr_ready_o),
        .mst_cr_resp_i(mst_cr_resp),
        .mst_cd_valid_i(mst_cd_valid), .mst_cd_ready_o(mst_cd_ready_o),
        .mst_cd_data_i(mst_cd_data), .mst_cd_last_i(mst_cd_last)
    );

    int vec = 0;
    int err = 0;

    // Transaction configuration
    logic [N-1:0]  t_mask;
    logic [AW-1:0] t_addr;
    logic [3:0]    t_snoop;
    logic [2:0]    t_prot;
    logic [4:0]    t_resp [N];
    int            t_beats [N];
    int            t_ac_delay [N];
    bit            t_early_cr [N];
    int unsigned   t_crr_pct, t_cdr_pct;
    logic [DW-1:0] t_data [N][MAXB];

    // Observations of one transaction
    logic [4:0]    o_cr_q [$];
    logic [DW:0]   o_fwd_q [$];
    int            o_sent [N];
    int            o_ac_hs_cyc [N];
    int            o_cr_acc_cyc [N];
    bit            m_cr_given [N];
    int            o_ac_cyc, o_first_crv, o_cr_hs_cyc;
    int            o_cr_unstable, o_cd_unstable, o_ac_bad, o_bc_bad, o_early_cr, o_early_cd;
    bit            o_ac_any, o_timeout;

    task automatic clear_inputs();
        slv_ac_valid = 1'b0; slv_ac_addr = '0; slv_ac_snoop = '0; slv_ac_prot = '0;
        slv_ac_mask = '0; slv_cr_ready = 1'b0; slv_cd_ready = 1'b0;
        mst_ac_ready = '0; mst_cr_valid = '0; mst_cr_resp = '0;
        mst_cd_valid = '0; mst_cd_data = '0; mst_cd_last = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic default_cfg();
        t_mask = '0; t_addr = {$urandom(), $urandom()};
        t_snoop = 4'($urandom()); t_prot = 3'($urandom());
        t_crr_pct = 100; t_cdr_pct = 100;
        for (int i = 0; i < N; i++) begin
            t_resp[i] = '0; t_beats[i] = 1; t_ac_delay[i] = 0; t_early_cr[i] = 1'b0;
            for (int k = 0; k < MAXB; k++) t_data[i][k] = {$urandom(), $urandom()};
        end
    endtask

    // Cache models: AC ready after a delay, CR once per AC, CD beats after own CR.
    task automatic update_inputs(input int c);
        for (int i = 0; i < N; i++) begin
            mst_ac_ready[i] = (c >= t_ac_delay[i]);
            mst_cr_valid[i] = t_mask[i] && !m_cr_given[i] && (t_early_cr[i] || o_ac_hs_cyc[i] >= 0);
            mst_cr_resp[5*i +: 5] = t_resp[i];
            if (t_mask[i] && t_resp[i][0] && m_cr_given[i] && o_sent[i] < t_beats[i]) begin
                mst_cd_valid[i] = 1'b1;
                mst_cd_data[DW*i +: DW] = t_data[i][o_sent[i]];
                mst_cd_last[i] = (o_sent[i] == t_beats[i] - 1);
            end else begin
                mst_cd_valid[i] = 1'b0;
                mst_cd_data[DW*i +: DW] = '0;
                mst_cd_last[i] = 1'b0;
            end
        end
        slv_cr_ready = ($urandom_range(99) < t_crr_pct);
        slv_cd_ready = ($urandom_range(99) < t_cdr_pct);
    endtask

    task automatic run_txn();
        bit prev_cr_stall, prev_cd_stall, done;
        logic [4:0] prev_resp;
        logic [DW-1:0] prev_data;
        logic prev_last;
        int cyc;
        o_cr_q.delete(); o_fwd_q.delete();
        for (int i = 0; i < N; i++) begin
            o_sent[i] = 0; o_ac_hs_cyc[i] = -1; o_cr_acc_cyc[i] = -1; m_cr_given[i] = 1'b0;
        end
        o_ac_cyc = -1; o_first_crv = -1; o_cr_hs_cyc = -1;
        o_cr_unstable = 0; o_cd_unstable = 0; o_ac_bad = 0; o_bc_bad = 0;
        o_early_cr = 0; o_early_cd = 0; o_ac_any = 1'b0; o_timeout = 1'b0;
        prev_cr_stall = 1'b0; prev_cd_stall = 1'b0; done = 1'b0;
        prev_resp = '0; prev_data = '0; prev_last = 1'b0; cyc = 0;
        slv_ac_valid = 1'b1; slv_ac_addr = t_addr; slv_ac_snoop = t_snoop;
        slv_ac_prot = t_prot; slv_ac_mask = t_mask;
        update_inputs(0);
        while (!done) begin
            @(negedge clk);
            if (slv_ac_valid && slv_ac_ready_o) o_ac_cyc = cyc;
            if (slv_cr_valid_o && o_first_crv < 0) o_first_crv = cyc;
            if (prev_cr_stall && (!slv_cr_valid_o || slv_cr_resp_o !== prev_resp)) o_cr_unstable++;
            if (prev_cd_stall && (!slv_cd_valid_o || slv_cd_data_o !== prev_data ||
                                  slv_cd_last_o !== prev_last)) o_cd_unstable++;
            prev_cr_stall = slv_cr_valid_o && !slv_cr_ready;
            prev_cd_stall = slv_cd_valid_o && !slv_cd_ready;
            prev_resp = slv_cr_resp_o; prev_data = slv_cd_data_o; prev_last = slv_cd_last_o;
            if (slv_cr_valid_o && slv_cr_ready) begin
                o_cr_q.push_back(slv_cr_resp_o);
                if (o_cr_hs_cyc < 0) o_cr_hs_cyc = cyc;
            end
            if (slv_cd_valid_o && slv_cd_ready) o_fwd_q.push_back({slv_cd_last_o, slv_cd_data_o});
            if (mst_ac_valid_o != '0) begin
                o_ac_any = 1'b1;
                if ({mst_ac_addr_o, mst_ac_snoop_o, mst_ac_prot_o} !== {t_addr, t_snoop, t_prot}) o_bc_bad++;
            end
            for (int i = 0; i < N; i++) begin
                if (mst_ac_valid_o[i] && !t_mask[i]) o_ac_bad++;
                if (mst_ac_valid_o[i] && mst_ac_ready[i] && o_ac_hs_cyc[i] < 0) o_ac_hs_cyc[i] = cyc;
                if (mst_cr_valid[i] && mst_cr_ready_o[i]) begin
                    if (o_ac_hs_cyc[i] < 0 || o_ac_hs_cyc[i] >= cyc) o_early_cr++;
                    o_cr_acc_cyc[i] = cyc;
                    m_cr_given[i] = 1'b1;
                end
                if (mst_cd_valid[i] && mst_cd_ready_o[i]) begin
                    if (o_cr_hs_cyc < 0 || cyc <= o_cr_hs_cyc) o_early_cd++;
                    o_sent[i]++;
                end
            end
            if (o_cr_hs_cyc >= 0 && cyc > o_cr_hs_cyc && slv_ac_ready_o) done = 1'b1;
            if (cyc > 2000) begin o_timeout = 1'b1; done = 1'b1; end
            @(posedge clk);
            #1;
            if (o_ac_cyc >= 0) slv_ac_valid = 1'b0;
            cyc++;
            update_inputs(cyc);
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        vec++;
        if ({mst_ac_valid_o, slv_cr_valid_o, slv_cd_valid_o, mst_cr_ready_o, mst_cd_ready_o, slv_ac_ready_o} !== '0) begin
            err++;
            $display("FAIL reset_valids: got ac=%b crv=%b cdv=%b crr=%b cdr=%b acr=%b want all 0",
                     mst_ac_valid_o, slv_cr_valid_o, slv_cd_valid_o, mst_cr_ready_o, mst_cd_ready_o, slv_ac_ready_o);
        end
        vec++;
        if ({slv_cr_resp_o, mst_ac_addr_o, mst_ac_snoop_o, mst_ac_prot_o} !== '0) begin
            err++;
            $display("FAIL reset_regs: got resp=%h addr=%h want 0", slv_cr_resp_o, mst_ac_addr_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vec++;
        if (slv_ac_ready_o !== 1'b1 || mst_ac_valid_o !== '0) begin
            err++;
            $display("FAIL reset_idle: got ac_ready=%b ac_valid=%b want 1/0", slv_ac_ready_o, mst_ac_valid_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        default_cfg();
        t_mask = 4'b0101;
        run_txn();
        vec++;
        if (o_timeout !== 1'b0) begin err++; $display("FAIL basic_timeout: got 1 want 0"); end
        vec++;
        if (o_cr_q.size() != 1 || o_cr_q[0] !== 5'b0) begin
            err++; $display("FAIL basic_resp: got n=%0d resp=%b want 1 x 00000", o_cr_q.size(), o_cr_q[0]);
        end
        vec++;
        if (o_fwd_q.size() != 0 || o_ac_bad != 0 || o_bc_bad != 0) begin
            err++; $display("FAIL basic_side: got beats=%0d ac_bad=%0d bc_bad=%0d want 0/0/0",
                            o_fwd_q.size(), o_ac_bad, o_bc_bad);
        end
    endtask

    task automatic test_merge_data();
        logic [DW:0] want;
        do_reset();
        default_cfg();
        t_mask = 4'b0110;
        t_resp[1] = 5'b01001; t_resp[2] = 5'b00101;
        t_beats[1] = 8; t_beats[2] = 8;
        run_txn();
        vec++;
        if (o_timeout !== 1'b0 || o_cr_q.size() != 1 || o_cr_q[0] !== 5'b01101) begin
            err++; $display("FAIL merge_resp: got n=%0d resp=%b to=%b want 1 x 01101", o_cr_q.size(), o_cr_q[0], o_timeout);
        end
        vec++;
        if (o_fwd_q.size() != 8) begin err++; $display("FAIL merge_beats: got %0d want 8", o_fwd_q.size()); end
        for (int k = 0; k < 8 && k < o_fwd_q.size(); k++) begin
            want = {k == 7, t_data[1][k]};
            vec++;
            if (o_fwd_q[k] !== want) begin err++; $display("FAIL merge_beat%0d: got %h want %h", k, o_fwd_q[k], want); end
        end
        vec++;
        if (o_sent[2] != 8 || o_sent[1] != 8 || o_early_cd != 0) begin
            err++; $display("FAIL merge_drain: got sent1=%0d sent2=%0d early=%0d want 8/8/0", o_sent[1], o_sent[2], o_early_cd);
        end
    endtask

    task automatic test_zero_mask();
        do_reset();
        default_cfg();
        t_mask = 4'b0000;
        run_txn();
        vec++;
        if (o_first_crv - o_ac_cyc != 1) begin
            err++; $display("FAIL zero_latency: got %0d want 1", o_first_crv - o_ac_cyc);
        end
        vec++;
        if (o_cr_q.size() != 1 || o_cr_q[0] !== 5'b0 || o_ac_any !== 1'b0) begin
            err++; $display("FAIL zero_resp: got n=%0d resp=%b ac_any=%b want 1/00000/0", o_cr_q.size(), o_cr_q[0], o_ac_any);
        end
    endtask

    task automatic test_early_cr();
        do_reset();
        default_cfg();
        t_mask = 4'b1000;
        t_resp[3] = 5'b10010;
        t_early_cr[3] = 1'b1;
        t_ac_delay[3] = 6;
        run_txn();
        vec++;
        if (o_ac_hs_cyc[3] != 6) begin err++; $display("FAIL early_ac_hs: got %0d want 6", o_ac_hs_cyc[3]); end
        vec++;
        if (o_cr_acc_cyc[3] != o_ac_hs_cyc[3] + 1 || o_early_cr != 0) begin
            err++; $display("FAIL early_cr_accept: got cyc=%0d early=%0d want %0d/0", o_cr_acc_cyc[3], o_early_cr, o_ac_hs_cyc[3] + 1);
        end
        vec++;
        if (o_cr_q.size() != 1 || o_cr_q[0] !== 5'b10010) begin
            err++; $display("FAIL early_resp: got %b want 10010", o_cr_q[0]);
        end
    endtask

    task automatic test_random_stall();
        logic [4:0] exp_resp;
        logic [DW:0] want;
        int src, nb, bad;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            default_cfg();
            t_mask = N'($urandom());
            t_crr_pct = 50; t_cdr_pct = 50;
            for (int i = 0; i < N; i++) begin
                t_resp[i] = 5'($urandom());
                t_beats[i] = int'($urandom_range(8, 1));
                t_ac_delay[i] = int'($urandom_range(4));
                t_early_cr[i] = bit'($urandom_range(1));
            end
            run_txn();
            exp_resp = '0; src = -1;
            for (int i = 0; i < N; i++) begin
                if (t_mask[i]) begin
                    exp_resp = exp_resp | t_resp[i];
                    if (t_resp[i][0] && src < 0) src = i;
                end
            end
            nb = (src >= 0) ? t_beats[src] : 0;
            vec++;
            if (o_timeout !== 1'b0 || o_cr_q.size() != 1 || o_cr_q[0] !== exp_resp) begin
                err++; $display("FAIL rnd%0d_resp: got n=%0d resp=%b to=%b want 1 x %b", t, o_cr_q.size(), o_cr_q[0], o_timeout, exp_resp);
            end
            bad = (o_fwd_q.size() != nb) ? 1 : 0;
            for (int k = 0; k < nb && k < o_fwd_q.size(); k++) begin
                want = {k == nb - 1, t_data[src][k]};
                if (o_fwd_q[k] !== want) bad++;
            end
            vec++;
            if (bad != 0) begin err++; $display("FAIL rnd%0d_fwd: got %0d beats, %0d bad want %0d beats", t, o_fwd_q.size(), bad, nb); end
            bad = 0;
            for (int i = 0; i < N; i++) begin
                if (t_mask[i] && t_resp[i][0] && o_sent[i] != t_beats[i]) bad++;
            end
            vec++;
            if (bad != 0 || o_early_cd != 0 || o_early_cr != 0) begin
                err++; $display("FAIL rnd%0d_drain: got bad=%0d early_cd=%0d early_cr=%0d want 0/0/0", t, bad, o_early_cd, o_early_cr);
            end
            vec++;
            if (o_cr_unstable != 0 || o_cd_unstable != 0 || o_ac_bad != 0 || o_bc_bad != 0) begin
                err++; $display("FAIL rnd%0d_stable: got cr=%0d cd=%0d ac_bad=%0d bc_bad=%0d want 0", t,
                                o_cr_unstable, o_cd_unstable, o_ac_bad, o_bc_bad);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        clear_inputs();
        slv_ac_valid = 1'b1; slv_ac_mask = 4'hF; slv_ac_addr = {$urandom(), $urandom()};
        @(posedge clk); #1;
        slv_ac_valid = 1'b0;
        @(posedge clk); #1;
        vec++;
        if (mst_ac_valid_o !== 4'hF) begin err++; $display("FAIL midrst_snoop: got %b want 1111", mst_ac_valid_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        vec++;
        if ({mst_ac_valid_o, slv_cr_valid_o, slv_cd_valid_o, mst_cr_ready_o, mst_cd_ready_o} !== '0) begin
            err++; $display("FAIL midrst_valids: got ac=%b crv=%b cdv=%b want 0", mst_ac_valid_o, slv_cr_valid_o, slv_cd_valid_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vec++;
        if (slv_ac_ready_o !== 1'b1) begin err++; $display("FAIL midrst_ready: got %b want 1", slv_ac_ready_o); end
        default_cfg();
        t_mask = 4'b0011;
        t_resp[0] = 5'b00011; t_resp[1] = 5'b01000;
        t_beats[0] = 4;
        run_txn();
        vec++;
        if (o_timeout !== 1'b0 || o_cr_q.size() != 1 || o_cr_q[0] !== 5'b01011 || o_fwd_q.size() != 4) begin
            err++; $display("FAIL midrst_txn: got resp=%b beats=%0d to=%b want 01011/4/0", o_cr_q[0], o_fwd_q.size(), o_timeout);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_merge_data();
        test_zero_mask();
        test_early_cr();
        test_random_stall();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
